// File: rtl/image_spike_encoder.sv
// Rate-codes an image into AER spike events with a per-pixel phase accumulator, one marker per timestep.
// Optional ENCODER_SPIKE_CNT_EN adds SPIKE_COUNT, a saturating count of spike events for the current image.
module image_spike_encoder #(
  parameter int N               = 256,
  parameter int M               = 8,
  parameter int IMAGE_SIZE      = 256,
  parameter int PIXEL_MAX_VALUE = 255,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int NUM_STEPS       = 8,
  parameter int STEP_BITS       = $clog2(NUM_STEPS)
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0]  IMAGE,
  input  logic                                   NEW_IMAGE,
  output logic [M:0]                             AEROUT_ADDR,
  output logic                                   AEROUT_REQ,
  input  logic                                   AEROUT_ACK,
  output logic                                   BUSY,
  output logic                                   DONE
`ifdef ENCODER_SPIKE_CNT_EN
  ,
  output logic [M+STEP_BITS:0]                   SPIKE_COUNT
`endif
);

  if (IMAGE_SIZE > N || NUM_STEPS < 2 || NUM_STEPS > 2**M) begin : g_bad_cfg
    $error("image_spike_encoder: unsupported parameter set");
  end

  localparam int THRESH = 2**PIXEL_BITS;

  // IDLE wait start | SCAN one pixel/cycle | REQ_HI wait ACK | ACK_LO wait ACK low | MARK load marker | STEP next timestep
  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_REQ_HI, S_ACK_LO, S_MARK, S_STEP
  } state_t;

  state_t                                 state_q, state_d;
  logic [M-1:0]                           idx_q, idx_d;
  logic [STEP_BITS-1:0]                   t_q, t_d;
  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0]  acc_q, acc_d;
  logic [M:0]                             addr_q, addr_d;
  logic                                   req_q, req_d;
  logic                                   mark_q, mark_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;
  logic                                   nimg_q;
  logic                                   arm_q;
  logic [PIXEL_BITS:0]                    sum;
  logic                                   spike;
  logic                                   last_pix;
  logic                                   last_step;
  logic                                   start;

  assign sum       = {1'b0, acc_q[idx_q]} + {1'b0, IMAGE[idx_q]};
  assign spike     = (sum >= (PIXEL_BITS+1)'(THRESH));
  assign last_pix  = (idx_q == M'(IMAGE_SIZE-1));
  assign last_step = (t_q == STEP_BITS'(NUM_STEPS-1));
  // arm_q keeps a level held high across reset release from counting as a fresh edge
  assign start     = (state_q == S_IDLE) && NEW_IMAGE && !nimg_q && arm_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    t_d     = t_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    mark_d  = mark_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = '0;
          t_d     = '0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // sum < 2*THRESH, so the low bits are sum-THRESH on overflow and sum otherwise
        acc_d[idx_q] = sum[PIXEL_BITS-1:0];
        if (spike) begin
          addr_d  = {1'b0, idx_q};
          mark_d  = 1'b0;
          req_d   = 1'b1;
          state_d = S_REQ_HI;
        end else if (last_pix) begin
          state_d = S_MARK;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_REQ_HI: begin
        if (AEROUT_ACK) begin
          req_d   = 1'b0;
          state_d = S_ACK_LO;
        end
      end
      S_ACK_LO: begin
        if (!AEROUT_ACK) begin
          if (mark_q) begin
            state_d = S_STEP;
          end else if (last_pix) begin
            state_d = S_MARK;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SCAN;
          end
        end
      end
      S_MARK: begin
        addr_d  = {1'b1, M'(t_q)};
        mark_d  = 1'b1;
        req_d   = 1'b1;
        state_d = S_REQ_HI;
      end
      S_STEP: begin
        idx_d = '0;
        if (last_step) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          t_d     = t_q + 1'b1;
          state_d = S_SCAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      t_q     <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      mark_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nimg_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      mark_q  <= mark_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nimg_q  <= NEW_IMAGE;
      arm_q   <= arm_q | ~NEW_IMAGE;
    end
  end

  assign AEROUT_ADDR = addr_q;
  assign AEROUT_REQ  = req_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;

`ifdef ENCODER_SPIKE_CNT_EN
  logic [M+STEP_BITS:0] cnt_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (state_q == S_REQ_HI && AEROUT_ACK && !mark_q && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign SPIKE_COUNT = cnt_q;
`endif

endmodule

// File: tb/tb_image_spike_encoder.sv
// Randomised bench for image_spike_encoder: an event-list model built from the rate-coding rule
// floor((t+1)*p/256) != floor(t*p/256), compared against every AER event the DUT emits.
module tb_image_spike_encoder;
  localparam int IS = 256;
  localparam int NS = 8;
  localparam int M  = 8;
  localparam int SB = 3;
  localparam int THR = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              new_image;
  logic              ack;
  logic              req;
  logic              busy;
  logic              done;
  logic [IS-1:0][7:0] image;
  logic [M:0]        addr;
`ifdef ENCODER_SPIKE_CNT_EN
  logic [M+SB:0]     spike_count;
`endif

  int          total = 0;
  int          bad = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  dut_log[$];
  int          done_cnt = 0;
  logic        req_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic [8:0]  last_addr = '0;
  int          stall = 0;
  bit          lat_rnd = 1'b0;
  logic [8:0]  lit2[12];

  always #5 clk = ~clk;

  image_spike_encoder dut (
    .ACLK        (clk),
    .ARESETN     (rst_n),
    .IMAGE       (image),
    .NEW_IMAGE   (new_image),
    .AEROUT_ADDR (addr),
    .AEROUT_REQ  (req),
    .AEROUT_ACK  (ack),
    .BUSY        (busy),
    .DONE        (done)
`ifdef ENCODER_SPIKE_CNT_EN
    ,
    .SPIKE_COUNT (spike_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] log_at(input int i);
    if (i >= 0 && i < dut_log.size()) return dut_log[i];
    return 9'h1FF;
  endfunction

  // Expected event stream straight from the rate-coding rule, no accumulator state.
  task automatic build_expect(output int nspk);
    exp_q.delete();
    nspk = 0;
    for (int t = 0; t < NS; t++) begin
      for (int i = 0; i < IS; i++) begin
        int p;
        p = int'(image[i]);
        if (((t + 1) * p) / THR != (t * p) / THR) begin
          exp_q.push_back(9'(i));
          nspk++;
        end
      end
      exp_q.push_back(9'h100 | 9'(t));
    end
  endtask

  task automatic rand_image();
    for (int i = 0; i < IS; i++)
      image[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    image[IS-1] = 8'($urandom_range(128, 255));
  endtask

  task automatic wait_done(input string nm, input int nspk);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, (done_cnt != d0) ? 32'd1 : 32'd0, 32'd1);
    chk({nm, "_events_left"}, exp_q.size(), 0);
`ifdef ENCODER_SPIKE_CNT_EN
    chk({nm, "_spike_count"}, 32'(spike_count), (nspk > 4095) ? 32'd4095 : 32'(nspk));
`else
    if (nspk < 0) chk({nm, "_nspk"}, nspk, 0);
`endif
  endtask

  task automatic run_image(input string nm, input int nspk);
    dut_log.delete();
    @(negedge clk);
    new_image = 1'b1;
    @(negedge clk);
    chk({nm, "_busy_start"}, busy, 1);
    wait_done(nm, nspk);
    @(negedge clk);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_done_pulse"}, done, 0);
    new_image = 1'b0;
    @(negedge clk);
  endtask

  // ACK responder: 4-phase echo with optional random latency and a one-shot stall.
  initial begin : responder
    int cnt;
    int tgt;
    cnt = 0;
    tgt = 0;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        ack = 1'b0;
        cnt = 0;
        stall = 0;
      end else if (req !== ack) begin
        if (cnt == 0) tgt = stall + (lat_rnd ? int'($urandom_range(0, 3)) : 0);
        if (cnt >= tgt) begin
          ack = req;
          cnt = 0;
          stall = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Compare process: every event against the model, ADDR stability, BUSY/DONE consistency.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      req_prev = 1'b0;
      done_prev = 1'b0;
      last_addr = '0;
      exp_q.delete();
    end else begin
      if (req && !req_prev) begin
        chk("busy_during_event", busy, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", addr, 9'h1FF);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("event_addr", addr, e);
        end
        dut_log.push_back(addr);
        last_addr = addr;
      end else begin
        chk("addr_stable", addr, last_addr);
      end
      if (done) begin
        done_cnt++;
        chk("done_busy_low", busy, 0);
        chk("done_no_pending", exp_q.size(), 0);
        chk("done_single_cycle", done_prev, 0);
      end
      req_prev = req;
      done_prev = done;
    end
  end

  initial begin : main
    int nspk;
    int n;
    int c0;
    int c255;
    int d0;
    logic [8:0] a0;
    lit2 = '{9'h100, 9'h005, 9'h101, 9'h102, 9'h005, 9'h103,
             9'h104, 9'h005, 9'h105, 9'h106, 9'h005, 9'h107};
    rst_n = 1'b0;
    new_image = 1'b0;
    image = '0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
`ifdef ENCODER_SPIKE_CNT_EN
    chk("rst_spike_count", spike_count, 0);
`endif
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // all-zero image: markers only
    image = '0;
    build_expect(nspk);
    chk("t1_model_len", exp_q.size(), 8);
    chk("t1_model_first", exp_q[0], 9'h100);
    chk("t1_model_last", exp_q[7], 9'h107);
    run_image("t1", nspk);
    chk("t1_log_len", dut_log.size(), 8);
    chk("t1_log_last", log_at(7), 9'h107);

    // single mid-level pixel
    image = '0;
    image[5] = 8'd128;
    build_expect(nspk);
    run_image("t2", nspk);
    chk("t2_log_len", dut_log.size(), 12);
    for (int i = 0; i < 12; i++) chk($sformatf("t2_log_%0d", i), log_at(i), lit2[i]);

    // full pixel at index 0, quarter pixel at last index
    image = '0;
    image[0] = 8'd255;
    image[IS-1] = 8'd64;
    build_expect(nspk);
    chk("t3_model_spikes", nspk, 9);
    run_image("t3", nspk);
    c0 = 0;
    c255 = 0;
    foreach (dut_log[i]) begin
      if (dut_log[i] == 9'h000) c0++;
      if (dut_log[i] == 9'h0FF) c255++;
    end
    chk("t3_idx0_spikes", c0, 7);
    chk("t3_idx255_spikes", c255, 2);
    chk("t3_tail_spike", log_at(dut_log.size() - 2), 9'h0FF);
    chk("t3_tail_marker", log_at(dut_log.size() - 1), 9'h107);

    // long ACK stall on first spike
    rand_image();
    build_expect(nspk);
    dut_log.delete();
    stall = 20;
    @(negedge clk);
    new_image = 1'b1;
    n = 0;
    while (!req && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_req_seen", req, 1);
    a0 = addr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_req_held", req, 1);
      chk("t4_addr_held", addr, a0);
    end
    wait_done("t4", nspk);
    @(negedge clk);
    new_image = 1'b0;
    @(negedge clk);
    lat_rnd = 1'b1;

    // second edge while busy is ignored; a fresh edge in IDLE restarts with cleared accumulators
    rand_image();
    build_expect(nspk);
    dut_log.delete();
    d0 = done_cnt;
    @(negedge clk);
    new_image = 1'b1;
    repeat (40) @(negedge clk);
    new_image = 1'b0;
    repeat (3) @(negedge clk);
    new_image = 1'b1;
    @(negedge clk);
    chk("t5_busy_mid", busy, 1);
    wait_done("t5a", nspk);
    repeat (30) @(negedge clk);
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_idle_busy", busy, 0);
    new_image = 1'b0;
    @(negedge clk);
    build_expect(nspk);
    run_image("t5b", nspk);

    // reset during a handshake
    rand_image();
    build_expect(nspk);
    dut_log.delete();
    stall = 30;
    @(negedge clk);
    new_image = 1'b1;
    n = 0;
    while (!req && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_req_seen", req, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", req, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", addr, 0);
    chk("t6_rst_done", done, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || req !== 1'b0) n++;
    end
    chk("t6_no_start_held_high", n, 0);
    new_image = 1'b0;
    @(negedge clk);
    build_expect(nspk);
    run_image("t6", nspk);

    // random images with random ACK latency
    for (int k = 0; k < 2; k++) begin
      rand_image();
      build_expect(nspk);
      run_image($sformatf("t7_%0d", k), nspk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
